// File: rtl/lfsr_clock_div_n_if.sv
// Control/status bundle for lfsr_clock_div_n.
// Optional lockup status exists only with LFSR_DIV_LOCKUP_DET_EN.
interface lfsr_clock_div_n_if #(
    parameter int WIDTH = 26
);
    logic             en;
    logic [WIDTH-1:0] term_in;
    logic             term_load;
    logic             term_pending;
    logic             tick;
    logic             q;
`ifdef LFSR_DIV_LOCKUP_DET_EN
    logic             lockup;
`endif

    modport master (
        output en, term_in, term_load,
        input  term_pending, tick, q
`ifdef LFSR_DIV_LOCKUP_DET_EN
        , input lockup
`endif
    );

    modport slave (
        input  en, term_in, term_load,
        output term_pending, tick, q
`ifdef LFSR_DIV_LOCKUP_DET_EN
        , output lockup
`endif
    );
endinterface

// File: rtl/lfsr_clock_div_n.sv
// Fibonacci LFSR clock divider with shadowed terminal reload.
// Define LFSR_DIV_LOCKUP_DET_EN for zero-state/watchdog recovery.
module lfsr_clock_div_n #(
    parameter int               WIDTH = 26,
    parameter logic [WIDTH-1:0] TAPS  = 26'h2000023,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter logic [WIDTH-1:0] TERM  = 26'd45641777,
    parameter int               MODE  = 0
) (
    input logic               clk,
    input logic               rst_n,
    lfsr_clock_div_n_if.slave bus
);
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] term_active;
    logic [WIDTH-1:0] shadow;
    logic             pending_q;
    logic             tick_q;
    logic             q_q;
    logic             fb;
    logic             wrap;
    logic             recover;

    assign fb   = ^(lfsr & TAPS);
    assign wrap = bus.en && (lfsr == term_active);

`ifdef LFSR_DIV_LOCKUP_DET_EN
    logic [WIDTH-1:0] wd;
    logic             lockup_q;

    // Zero state or a full 2^WIDTH enabled cycles with no wrap.
    assign recover = bus.en && !wrap && ((lfsr == '0) || (&wd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd       <= '0;
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= recover;
            if (wrap || recover) begin
                wd <= '0;
            end else if (bus.en) begin
                wd <= wd + 1'b1;
            end
        end
    end

    assign bus.lockup = lockup_q;
`else
    assign recover = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (wrap || recover) begin
            lfsr <= SEED;
        end else if (bus.en) begin
            lfsr <= {lfsr[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            q_q    <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (MODE == 0) begin
                if (wrap) begin
                    q_q <= ~q_q;
                end
            end else begin
                q_q <= wrap;
            end
        end
    end

    // A new terminal only takes effect at a wrap, so no period is cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_active <= TERM;
            shadow      <= TERM;
            pending_q   <= 1'b0;
        end else if (wrap && bus.term_load) begin
            term_active <= bus.term_in;
            shadow      <= bus.term_in;
            pending_q   <= 1'b0;
        end else if (wrap) begin
            term_active <= shadow;
            pending_q   <= 1'b0;
        end else if (bus.term_load) begin
            shadow    <= bus.term_in;
            pending_q <= 1'b1;
        end
    end

    assign bus.term_pending = pending_q;
    assign bus.tick         = tick_q;
    assign bus.q            = q_q;
endmodule
